// File: rtl/render_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : render_sequencer
//  Purpose  : Frame-level scheduler for the drawing stages that share the
//             VGA/ROM tristate buses. On each frame tick the stages are
//             started one at a time in fixed order (stage 0 = map drawer),
//             each with a one-cycle draw pulse, and the sequencer waits for
//             that stage's done before moving on. It also supplies the map
//             ROM base address for the current level and raises sticky
//             flags for dropped ticks and watchdog-abandoned stages.
//  Ports    : clk, resetn (async, active-low)
//             frame_tick       - one-cycle frame start request
//             level[1:0]       - map selector, sampled at frame start
//             clear_errors     - clears overrun / timeout_err
//             stage_done[N-1:0]- per-stage done pulses
//             stage_draw[N-1:0]- per-stage one-cycle start pulses
//             map_tile_address - map ROM base, stable for a whole frame
//             busy, frame_done, overrun, timeout_err
//  Revision : 1.0 - initial release
// ============================================================================
module render_sequencer #(
    parameter int          NUM_STAGES  = 3,
    parameter logic [19:0] TIMEOUT     = 20'd100000,
    parameter logic [15:0] TILE_PIXELS = 16'd19200
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  frame_tick,
    input  logic [1:0]            level,
    input  logic                  clear_errors,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_draw,
    output logic [15:0]           map_tile_address,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  timeout_err
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_WAIT       = 2'd2,
        S_FRAME_DONE = 2'd3
    } state_t;

    state_t           state, next_state;
    logic [IDX_W-1:0] idx, next_idx;
    logic [19:0]      wd, next_wd;
    logic [15:0]      next_addr;
    logic             set_timeout;
    logic             set_overrun;
    logic [15:0]      level_base;

    // 16-bit product; level 3 wraps nothing (57600 fits) but the width is
    // deliberately 16 bits to match the ROM address bus.
    assign level_base = {14'd0, level} * TILE_PIXELS;

    // Any tick that arrives while a frame is in flight is dropped.
    assign set_overrun = frame_tick && (state != S_IDLE);

    // ------------------------------------------------------------------
    // Next-state / datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state  = state;
        next_idx    = idx;
        next_wd     = wd;
        next_addr   = map_tile_address;
        set_timeout = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (frame_tick) begin
                    next_idx   = '0;
                    next_addr  = level_base;
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                next_wd    = '0;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                next_wd = wd + 20'd1;
                // A done in the same cycle as the watchdog limit takes
                // priority, so the timeout flag is only raised without done.
                if (stage_done[idx] || (wd == TIMEOUT - 20'd1)) begin
                    set_timeout = !stage_done[idx];
                    if (idx == LAST_IDX) begin
                        next_state = S_FRAME_DONE;
                    end else begin
                        next_idx   = idx + IDX_W'(1);
                        next_state = S_ISSUE;
                    end
                end
            end
            S_FRAME_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and flag registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= S_IDLE;
            idx              <= '0;
            wd               <= '0;
            map_tile_address <= '0;
            overrun          <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            state            <= next_state;
            idx              <= next_idx;
            wd               <= next_wd;
            map_tile_address <= next_addr;

            // Set events win over a simultaneous clear.
            if (set_overrun)       overrun <= 1'b1;
            else if (clear_errors) overrun <= 1'b0;

            if (set_timeout)       timeout_err <= 1'b1;
            else if (clear_errors) timeout_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decodes (registered state only; the async reset of
    // the state register drops stage_draw without a clock edge)
    // ------------------------------------------------------------------
    always_comb begin
        stage_draw = '0;
        if (state == S_ISSUE) begin
            stage_draw[idx] = 1'b1;
        end
    end

    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_FRAME_DONE);

endmodule
`default_nettype wire
